// File: rtl/stonyman_capture_ctrl_if.sv
// Capture controller <-> APB block, pixel FIFO, sensor pins and ADC.
// Latency: none, wiring only.
// Backpressure: FULL from the pixel FIFO is the only backpressure signal.
interface stonyman_capture_ctrl_if;
  // APB register block
  logic       START_CAPTURE;
  logic       BUSY;
  // pixel FIFO producer side
  logic       FULL;
  logic       WREN;
  logic [7:0] PIXELOUT;
  // sensor pointer controls
  logic       RESP;
  logic       INCP;
  logic       RESV;
  logic       INCV;
  // external ADC
  logic       ADC_START;
  logic       ADC_DONE;
  logic [7:0] ADC_DATA;

  // controller side
  modport master (
    input  START_CAPTURE, FULL, ADC_DONE, ADC_DATA,
    output BUSY, WREN, PIXELOUT, RESP, INCP, RESV, INCV, ADC_START
  );

  // environment side (APB block, FIFO, sensor, ADC)
  modport slave (
    output START_CAPTURE, FULL, ADC_DONE, ADC_DATA,
    input  BUSY, WREN, PIXELOUT, RESP, INCP, RESV, INCV, ADC_START
  );
endinterface

// File: rtl/stonyman_capture_ctrl.sv
// Stonyman capture sequencer: walks row/col pointers over a frame, converts each pixel, writes it to the FIFO.
// Latency: first ADC_START 4*PULSE_CYCLES+SETTLE_CYCLES+1 cycles after request; per pixel CONV + ADC + WRITE.
// Backpressure: FULL is registered; WRITE holds (WREN high) while the sampled FULL is 1, no pixel is dropped.
module stonyman_capture_ctrl #(
  parameter int ROWS          = 112,
  parameter int COLS          = 112,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic PCLK,
  input  logic PRESERN,
  stonyman_capture_ctrl_if.master bus
);

  // A pointer pulse is PULSE_CYCLES high followed by PULSE_CYCLES low.
  localparam int PULSE_LEN = 2 * PULSE_CYCLES;
  localparam int CNT_MAX   = (PULSE_LEN > SETTLE_CYCLES) ? PULSE_LEN : SETTLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_HI   = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [6:0]    ROW_LAST   = 7'(ROWS - 1);
  localparam logic [6:0]    COL_LAST   = 7'(COLS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESV,
    S_RESP,
    S_SETTLE,
    S_CONV,
    S_WAITADC,
    S_WRITE,
    S_INCP,
    S_ROWRESP,
    S_INCV,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   phase_cnt;
  logic [6:0]      row;
  logic [6:0]      col;
  logic [7:0]      pixel;
  logic            full_q;

  logic            start_req;
  logic            pulse_state;
  logic            pulse_high;
  logic            pulse_end;
  logic            settle_end;
  logic            write_ok;

  assign start_req   = ~bus.START_CAPTURE;
  assign pulse_state = (state == S_RESV) || (state == S_RESP) || (state == S_INCP) ||
                       (state == S_ROWRESP) || (state == S_INCV);
  assign pulse_high  = pulse_state && (phase_cnt < PULSE_HI);
  assign pulse_end   = (phase_cnt == PULSE_LAST);
  assign settle_end  = (phase_cnt == SETTLE_LAST);
  // FULL is looked at one edge late so the FIFO flag never reaches WREN combinationally.
  assign write_ok    = (state == S_WRITE) && !full_q;

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: pointer setup, settle, convert, write, then advance the pointers.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start_req) state_next = S_RESV;
      S_RESV:    if (pulse_end) state_next = S_RESP;
      S_RESP:    if (pulse_end) state_next = S_SETTLE;
      S_SETTLE:  if (settle_end) state_next = S_CONV;
      S_CONV:    state_next = S_WAITADC;
      S_WAITADC: if (bus.ADC_DONE) state_next = S_WRITE;
      S_WRITE: begin
        if (write_ok) begin
          if (col < COL_LAST) begin
            state_next = S_INCP;
          end else if (row < ROW_LAST) begin
            state_next = S_ROWRESP;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_INCP:    if (pulse_end) state_next = S_SETTLE;
      S_ROWRESP: if (pulse_end) state_next = S_INCV;
      S_INCV:    if (pulse_end) state_next = S_SETTLE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registered data only.
  always_comb begin
    bus.BUSY      = (state != S_IDLE);
    bus.WREN      = ~write_ok;
    bus.PIXELOUT  = pixel;
    bus.RESV      = 1'b0;
    bus.RESP      = 1'b0;
    bus.INCP      = 1'b0;
    bus.INCV      = 1'b0;
    bus.ADC_START = (state == S_CONV);
    case (state)
      S_RESV:              bus.RESV = pulse_high;
      S_RESP, S_ROWRESP:   bus.RESP = pulse_high;
      S_INCP:              bus.INCP = pulse_high;
      S_INCV:              bus.INCV = pulse_high;
      default: ;
    endcase
  end

  // Phase counter times pulse high/low halves and the settle wait; restarts on every state change.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      phase_cnt <= '0;
    end else if (state_next != state) begin
      phase_cnt <= '0;
    end else if (pulse_state || (state == S_SETTLE)) begin
      phase_cnt <= phase_cnt + CW'(1);
    end
  end

  // Row/column pointers mirror the sensor's internal pointers; they move as each pulse completes.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      row <= '0;
      col <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req) begin
            row <= '0;
            col <= '0;
          end
        end
        S_INCP: begin
          if (pulse_end) col <= col + 7'd1;
        end
        S_INCV: begin
          if (pulse_end) begin
            row <= row + 7'd1;
            col <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel holding register: captures ADC_DATA only when the awaited conversion completes.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      pixel <= '0;
    end else if ((state == S_WAITADC) && bus.ADC_DONE) begin
      pixel <= bus.ADC_DATA;
    end
  end

  // FULL sample; reset to 1 so nothing can be written before a real sample is taken.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      full_q <= 1'b1;
    end else begin
      full_q <= bus.FULL;
    end
  end

  // The sensor tolerates only one pointer control at a time.
  a_ptr_onehot: assert property (@(posedge PCLK) disable iff (!PRESERN)
    $onehot0({bus.RESV, bus.RESP, bus.INCP, bus.INCV}));

  // Pointers stay inside the frame.
  a_row_range: assert property (@(posedge PCLK) disable iff (!PRESERN) row <= ROW_LAST);
  a_col_range: assert property (@(posedge PCLK) disable iff (!PRESERN) col <= COL_LAST);

  // A conversion start is always a single-cycle strobe.
  a_adc_start_1cyc: assert property (@(posedge PCLK) disable iff (!PRESERN)
    bus.ADC_START |=> !bus.ADC_START);

endmodule

// File: tb/tb_stonyman_capture_ctrl.sv
// Bench for stonyman_capture_ctrl: randomized FULL/idle gaps, scoreboard of expected pixels per frame.
// Latency: checks start-to-BUSY, settle-to-ADC_START, DONE-to-WREN and last-write-to-BUSY-fall timing.
// Backpressure: FULL stalls (fixed 10-cycle and random) must delay WREN without losing or reordering pixels.
module tb_stonyman_capture_ctrl;
  localparam int ROWS    = 2;
  localparam int COLS    = 3;
  localparam int P       = 2;
  localparam int S       = 3;
  localparam int NPIX    = ROWS * COLS;
  localparam int ADC_LAT = 4;

  logic PCLK = 1'b0;
  logic PRESERN;

  stonyman_capture_ctrl_if bus ();

  stonyman_capture_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)
  ) dut (
    .PCLK(PCLK),
    .PRESERN(PRESERN),
    .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  logic [7:0] adc_val = 8'h10;
  bit         in_frame = 1'b0;
  bit         stall_mode = 1'b0;
  bit         rand_full = 1'b0;
  bit         spur_req = 1'b0;
  int         conv_in_frame = 0;
  int         strobe_cnt = 0;
  int         last_strobe_cyc = 0;
  int         pulse_cnt[4];   // [3]=RESV [2]=RESP [1]=INCP [0]=INCV

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // ADC and FIFO model: DONE one cycle, ADC_LAT cycles after ADC_START; FULL stalls on request.
  initial begin
    int cd;
    int full_cd;
    cd = 0;
    full_cd = 0;
    bus.ADC_DONE = 1'b0;
    bus.ADC_DATA = 8'h00;
    bus.FULL = 1'b0;
    forever begin
      @(posedge PCLK);
      #1;
      bus.ADC_DONE = 1'b0;
      if (full_cd > 0) begin
        bus.FULL = 1'b1;
        full_cd--;
      end else if (rand_full) begin
        bus.FULL = ($urandom_range(0, 2) == 0);
      end else begin
        bus.FULL = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.ADC_DONE = 1'b1;
          bus.ADC_DATA = adc_val;
          adc_val++;
          if (stall_mode && conv_in_frame == 2) begin
            bus.FULL = 1'b1;
            full_cd = 9;
          end
          conv_in_frame++;
        end
      end else if (spur_req) begin
        bus.ADC_DONE = 1'b1;
        bus.ADC_DATA = 8'hA5;
        spur_req = 1'b0;
      end
      @(negedge PCLK);
      if (bus.ADC_START) cd = ADC_LAT;
    end
  end

  // Monitor: pops expected pixels on each WREN strobe, checks pointer pulse shapes and settle timing.
  initial begin
    bit         pend;
    bit         exp_now;
    bit         strobe;
    bit         prev_as;
    logic [3:0] pins;
    logic [3:0] prev_pins;
    int         run[4];
    int         last_ptr;
    pend = 0; exp_now = 0; prev_as = 0; prev_pins = '0; last_ptr = -1000;
    for (int i = 0; i < 4; i++) run[i] = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESERN) begin
        pend = 0; exp_now = 0; prev_as = 0; prev_pins = '0;
        for (int i = 0; i < 4; i++) run[i] = 0;
      end else begin
        strobe = !bus.WREN;
        if (strobe || exp_now) chk("wren_strobe", int'(strobe), int'(exp_now));
        if (strobe) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel_unexpected: got strobe with data 0x%0h required no strobe at cycle %0d", bus.PIXELOUT, cyc);
          end else begin
            chk("pixel_data", int'(bus.PIXELOUT), int'(exp_q.pop_front()));
          end
          strobe_cnt++;
          last_strobe_cyc = cyc;
        end
        // A completed conversion is written the cycle after the first FULL=0 sample from DONE onward.
        exp_now = 0;
        if (in_frame && bus.ADC_DONE) pend = 1;
        if (pend && !bus.FULL) begin
          exp_now = 1;
          pend = 0;
        end

        pins = {bus.RESV, bus.RESP, bus.INCP, bus.INCV};
        if (pins != 4'b0) chk("ptr_onehot", $countones(pins), 1);
        for (int i = 0; i < 4; i++) begin
          if (pins[i] && !prev_pins[i]) begin
            pulse_cnt[i]++;
            chk("ptr_low_gap", int'((cyc - last_ptr) > P), 1);
          end
          if (pins[i]) begin
            run[i]++;
          end else if (prev_pins[i]) begin
            chk("ptr_high_width", run[i], P);
            run[i] = 0;
          end
        end
        if (bus.ADC_START) begin
          chk("adc_start_width", int'(prev_as), 0);
          chk("settle_gap", cyc - last_ptr, P + S + 1);
        end
        if (pins != 4'b0) last_ptr = cyc;
        prev_as = bus.ADC_START;
        prev_pins = pins;
      end
    end
  end

  task automatic start_frame(input bit stall, input bit rnd);
    int base;
    base = int'(adc_val);
    for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(base + i));
    stall_mode = stall;
    rand_full = rnd;
    conv_in_frame = 0;
    strobe_cnt = 0;
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    in_frame = 1'b1;
    @(posedge PCLK); #1;
    bus.START_CAPTURE = 1'b0;
    @(negedge PCLK);
    chk("busy_before_start", int'(bus.BUSY), 0);
    @(posedge PCLK); #1;
    bus.START_CAPTURE = 1'b1;
    @(negedge PCLK);
    chk("busy_rise", int'(bus.BUSY), 1);
    chk("resv_rise", int'(bus.RESV), 1);
  endtask

  task automatic finish_frame();
    bit timed_out;
    timed_out = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge PCLK);
      if (!bus.BUSY) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("frame_timeout", int'(timed_out), 0);
    chk("busy_fall_cycle", cyc, last_strobe_cyc + 2);
    chk("strobe_count", strobe_cnt, NPIX);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("resv_pulses", pulse_cnt[3], 1);
    chk("resp_pulses", pulse_cnt[2], ROWS);
    chk("incp_pulses", pulse_cnt[1], ROWS * (COLS - 1));
    chk("incv_pulses", pulse_cnt[0], ROWS - 1);
    in_frame = 1'b0;
    rand_full = 1'b0;
    stall_mode = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required end within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s0;
    int  starts;
    bit  timed_out;
    bus.START_CAPTURE = 1'b1;
    PRESERN = 1'b0;
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    @(negedge PCLK);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_wren", int'(bus.WREN), 1);
    chk("rst_pixelout", int'(bus.PIXELOUT), 0);
    chk("rst_ptr_pins", int'({bus.RESV, bus.RESP, bus.INCP, bus.INCV}), 0);
    chk("rst_adc_start", int'(bus.ADC_START), 0);

    // Spurious ADC_DONE while idle.
    s0 = strobe_cnt;
    spur_req = 1'b1;
    repeat (6) @(negedge PCLK);
    chk("spur_strobes", strobe_cnt - s0, 0);
    chk("spur_busy", int'(bus.BUSY), 0);
    chk("spur_pixelout", int'(bus.PIXELOUT), 0);

    // Plain frame: 0x10..0x15.
    start_frame(1'b0, 1'b0);
    finish_frame();
    repeat (3) @(posedge PCLK);

    // FULL stall on third pixel plus an ignored mid-frame request: 0x16..0x1B.
    start_frame(1'b1, 1'b0);
    repeat (30) @(posedge PCLK);
    #1 bus.START_CAPTURE = 1'b0;
    @(posedge PCLK);
    #1 bus.START_CAPTURE = 1'b1;
    finish_frame();
    repeat (2) @(posedge PCLK);

    // Reset while waiting on the third conversion.
    start_frame(1'b0, 1'b0);
    starts = 1;   // first ADC_START is after the RESV pulse already observed
    starts = 0;
    timed_out = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (bus.ADC_START) starts++;
      if (starts == 3) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge PCLK);
    end
    chk("reset_wait_timeout", int'(timed_out), 0);
    chk("pre_reset_strobes", strobe_cnt, 2);
    @(posedge PCLK); #1;
    PRESERN = 1'b0;
    in_frame = 1'b0;
    @(posedge PCLK); #1;
    PRESERN = 1'b1;
    @(negedge PCLK);
    chk("midrst_busy", int'(bus.BUSY), 0);
    chk("midrst_wren", int'(bus.WREN), 1);
    chk("midrst_pixelout", int'(bus.PIXELOUT), 0);
    chk("midrst_ptr_pins", int'({bus.RESV, bus.RESP, bus.INCP, bus.INCV}), 0);
    exp_q.delete();
    s0 = strobe_cnt;
    repeat (10) @(negedge PCLK);
    chk("post_reset_strobes", strobe_cnt - s0, 0);
    chk("post_reset_busy", int'(bus.BUSY), 0);

    // Randomized FULL backpressure and idle gaps.
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(1, 8)) @(posedge PCLK);
      start_frame(1'b0, 1'b1);
      finish_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
